// File: rtl/mac_accum.sv
// mac_accum: int8 x int8 multiply-accumulate producer for the requantiser.
// A job loads a bias and a term count. Each accepted act/wgt pair is multiplied
// into a product register, and that product is added to the accumulator on the
// following cycle. The result is then presented with a valid/ready handshake.
// Optional build macro: MAC_ACC_SAT_EN. When it is defined, an overflowing add
// clamps the accumulator to the ACC_W limits. When it is undefined, the
// accumulator wraps.
module mac_accum #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [ACC_W-1:0]  bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] act,
  input  logic [DATA_W-1:0] wgt,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc,
  output logic              busy,
  output logic              ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

`ifdef MAC_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  logic [1:0]         state_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   remaining_reg;
  logic [ACC_W-1:0]   prod_q;
  logic               prod_v;
  logic               ovf_reg;

  logic signed [2*DATA_W-1:0] prod_full;
  logic [ACC_W-1:0]           prod_ext;
  logic [ACC_W-1:0]           sum;
  logic                       add_ovf;
  logic [ACC_W-1:0]           acc_add;
  logic                       hs;

  // The full 2*DATA_W product keeps -128*-128 exact. It is then sign-extended to ACC_W.
  assign prod_full = $signed(act) * $signed(wgt);
  assign prod_ext  = {{(ACC_W-2*DATA_W){prod_full[2*DATA_W-1]}}, prod_full};

  // The sum overflows when both operands have the same sign and the result sign differs.
  assign sum     = acc_reg + prod_q;
  assign add_ovf = (acc_reg[ACC_W-1] == prod_q[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_reg[ACC_W-1]);
`ifdef MAC_ACC_SAT_EN
  assign acc_add = add_ovf ? (acc_reg[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign acc_add = sum;
`endif

  assign in_ready  = (state_reg == S_ACCUM);
  assign acc_valid = (state_reg == S_OUT);
  assign busy      = (state_reg != S_IDLE);
  assign acc       = acc_reg;
  assign ovf       = ovf_reg;
  assign hs        = in_valid && in_ready;

  // Job FSM with a one-stage product pipeline feeding the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      acc_reg       <= '0;
      remaining_reg <= '0;
      prod_q        <= '0;
      prod_v        <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            acc_reg       <= bias;
            remaining_reg <= len;
            ovf_reg       <= 1'b0;
            prod_v        <= 1'b0;
            state_reg     <= (len == '0) ? S_OUT : S_ACCUM;
          end
        end
        S_ACCUM: begin
          // A product registered on the previous cycle is added exactly once,
          // even if the current cycle is a gap.
          if (prod_v) begin
            acc_reg <= acc_add;
            if (add_ovf) ovf_reg <= 1'b1;
          end
          prod_v <= hs;
          if (hs) begin
            prod_q        <= prod_ext;
            remaining_reg <= remaining_reg - 1'b1;
            if (remaining_reg == CNT_W'(1)) state_reg <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (prod_v) begin
            acc_reg <= acc_add;
            if (add_ovf) ovf_reg <= 1'b1;
          end
          prod_v    <= 1'b0;
          state_reg <= S_OUT;
        end
        S_OUT: begin
          if (acc_ready) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
// Testbench for mac_accum. It runs directed and randomised jobs and compares
// the results against an arithmetic reference model. The bench also honours
// MAC_ACC_SAT_EN.
module tb_mac_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  len;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  act;
  logic [7:0]  wgt;
  logic        acc_valid;
  logic        acc_ready;
  logic [31:0] acc;
  logic        busy;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  byte a_arr [0:15];
  byte w_arr [0:15];

  localparam longint MAXL = 64'sd2147483647;
  localparam longint MINL = -64'sd2147483648;

  mac_accum #(.DATA_W(8), .ACC_W(32), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .act(act), .wgt(wgt),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc(acc),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: run the exact running sum in 64-bit arithmetic.
  // Flag any step that leaves the int32 range, then wrap or clamp the sum.
  function automatic void model_job(input longint b, input int n,
                                    output logic [31:0] e_acc, output logic e_ovf);
    longint run;
    run   = b;
    e_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      run = run + longint'(a_arr[i]) * longint'(w_arr[i]);
      if (run > MAXL || run < MINL) begin
        e_ovf = 1'b1;
`ifdef MAC_ACC_SAT_EN
        run = (run > MAXL) ? MAXL : MINL;
`else
        run = longint'($signed(run[31:0]));
`endif
      end
    end
    e_acc = run[31:0];
  endfunction

  // Drive one complete job and check its latency, result, hold behaviour and return to IDLE.
  // gap_mode values: 0 = back-to-back, 1 = valid every other cycle, 2 = random.
  task automatic run_job(input logic signed [31:0] b, input int n, input int gap_mode,
                         input int hold, input string tag);
    logic [31:0] e_acc;
    logic        e_ovf;
    int          idx;
    int          guard;
    logic        v;
    logic        hsv;
    model_job(longint'(b), n, e_acc, e_ovf);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    start = 1'b1; len = n[9:0]; bias = b;
    @(negedge clk);
    start = 1'b0; len = '0; bias = '0;
    chk({tag, "_busy"}, busy, 1'b1);
    if (n == 0) begin
      chk({tag, "_len0_no_ready"}, in_ready, 1'b0);
    end else begin
      chk({tag, "_accum_ready"}, in_ready, 1'b1);
      idx = 0; guard = 0;
      while (idx < n && guard < 400) begin
        if (gap_mode == 0)      v = 1'b1;
        else if (gap_mode == 1) v = guard[0];
        else                    v = 1'($urandom_range(0, 1));
        in_valid = v; act = a_arr[idx]; wgt = w_arr[idx];
        hsv = v && in_ready;
        @(negedge clk);
        if (hsv) idx++;
        guard++;
      end
      in_valid = 1'b0;
      chk({tag, "_terms_accepted"}, 64'(idx), 64'(n));
      chk({tag, "_drain_valid"}, acc_valid, 1'b0);
      chk({tag, "_drain_ready"}, in_ready, 1'b0);
      @(negedge clk);
    end
    chk({tag, "_valid"}, acc_valid, 1'b1);
    chk({tag, "_acc"}, acc, e_acc);
    chk({tag, "_ovf"}, ovf, e_ovf);
    chk({tag, "_out_ready"}, in_ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; len = 10'd1;
      @(negedge clk);
      chk({tag, "_hold_valid"}, acc_valid, 1'b1);
      chk({tag, "_hold_acc"}, acc, e_acc);
      chk({tag, "_hold_ovf"}, ovf, e_ovf);
    end
    start = 1'b0; len = '0;
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    chk({tag, "_after_valid"}, acc_valid, 1'b0);
    chk({tag, "_after_busy"}, busy, 1'b0);
    $display("job %s bias=%0d len=%0d acc=%0d ovf=%0b expected acc=%0d ovf=%0b",
             tag, b, n, $signed(acc), ovf, $signed(e_acc), e_ovf);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; bias = '0;
    in_valid = 1'b0; act = '0; wgt = '0; acc_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_acc_valid", acc_valid, 1'b0);
    chk("rst_acc", acc, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;

    // Directed test: 100 + 6 - 20 - 7 = 79 with back-to-back terms.
    a_arr[0] = 2;  w_arr[0] = 3;
    a_arr[1] = -4; w_arr[1] = 5;
    a_arr[2] = 7;  w_arr[2] = -1;
    run_job(32'sd100, 3, 0, 0, "basic");
    chk("basic_const", acc, 32'd79);

    // Directed test: an empty job returns the bias on the next cycle.
    run_job(-32'sd5, 0, 0, 0, "len0");

    // Directed test: four (-128,-128) terms with gaps every other cycle give 65536.
    for (int i = 0; i < 4; i++) begin a_arr[i] = -128; w_arr[i] = -128; end
    run_job(32'sd0, 4, 1, 0, "maxprod");

    // Directed test: a positive overflow near the top of the range.
    a_arr[0] = 10; w_arr[0] = 20;
    run_job(32'sd2147483547, 1, 0, 0, "ovf");
    chk("ovf_flag", ovf, 1'b1);

    // Directed test: the result is held while acc_ready stays low, and start is ignored meanwhile.
    a_arr[0] = 5; w_arr[0] = 6;
    a_arr[1] = -3; w_arr[1] = 9;
    run_job(32'sd1000, 2, 0, 5, "hold");

    // Directed test: reset asserted after 2 of 4 terms.
    for (int i = 0; i < 4; i++) begin a_arr[i] = 11; w_arr[i] = 13; end
    @(negedge clk);
    start = 1'b1; len = 10'd4; bias = 32'd77;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; act = a_arr[0]; wgt = w_arr[0];
    repeat (2) @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_acc_valid", acc_valid, 1'b0);
    chk("midrst_acc", acc, 32'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ovf", ovf, 1'b0);
    a_arr[0] = 3; w_arr[0] = 3;
    run_job(32'sd0, 1, 0, 0, "postrst");
    chk("postrst_const", acc, 32'd9);

    // Randomised jobs, with biases sometimes near the range limits to provoke overflow.
    for (int j = 0; j < 24; j++) begin
      int n;
      logic [31:0] b;
      n = int'($urandom_range(0, 8));
      case (j % 4)
        1:       b = 32'h7FFF_F000 + 32'($urandom_range(0, 4095));
        3:       b = 32'h8000_0000 + 32'($urandom_range(0, 4095));
        default: b = $urandom;
      endcase
      for (int i = 0; i < 16; i++) begin
        a_arr[i] = byte'($urandom);
        w_arr[i] = byte'($urandom);
      end
      run_job($signed(b), n, 2, int'($urandom_range(0, 3)), $sformatf("rand%0d", j));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
